// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-ID peripheral with constants, scratch, uptime snapshot and seconds.
// Define SYSID_SECONDS_EN to build the prescaler and SECONDS counter (word 6 reads 0 otherwise).
module sysid_regs #(
    parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int unsigned CLK_FREQ_HZ   = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    logic [31:0] rdata_q, rdata_d, scratch_q, scratch_d, snap_q, snap_d, sec_word, rd_word;
    logic [63:0] uptime_q, uptime_d;
    logic        rvalid_q, clear;
    assign clear = write && address == 3'd7 && byteenable[0] && writedata[0];
    always_comb begin
        for (int i = 0; i < 4; i++)
            scratch_d[8*i +: 8] = (write && address == 3'd3 && byteenable[i]) ? writedata[8*i +: 8] : scratch_q[8*i +: 8];
    end
    assign uptime_d = clear ? 64'd0 : uptime_q + 64'd1;
    // CLEAR wins over a snapshot latch from a simultaneous word-4 read
    assign snap_d = clear ? 32'd0 : (read && address == 3'd4) ? uptime_q[63:32] : snap_q;
`ifdef SYSID_SECONDS_EN
    localparam int PW = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ_HZ - 1);
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   sec_q, sec_d;
    logic          tick;
    assign tick    = presc_q == TC;
    assign presc_d = (clear || tick) ? '0 : presc_q + 1'b1;
    assign sec_d   = clear ? 32'd0 : tick ? sec_q + 32'd1 : sec_q;
    assign sec_word = sec_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end
`else
    assign sec_word = 32'd0;
`endif
    always_comb begin
        case (address)
            3'd0:    rd_word = ID_VALUE;
            3'd1:    rd_word = TIMESTAMP;
            3'd2:    rd_word = VERSION;
            3'd3:    rd_word = scratch_q;
            3'd4:    rd_word = uptime_q[31:0];
            3'd5:    rd_word = snap_q;
            3'd6:    rd_word = sec_word;
            default: rd_word = 32'd0;
        endcase
    end
    assign rdata_d = read ? rd_word : rdata_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            scratch_q <= SCRATCH_RESET;
            uptime_q  <= '0;
            snap_q    <= '0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid_q  <= read;
            scratch_q <= scratch_d;
            uptime_q  <= uptime_d;
            snap_q    <= snap_d;
        end
    end
    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;
endmodule
